// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - DEPTH-entry IF/ID instruction queue with decode field split
// Fetch pushes {instruction, PC_next}; decode pops the head and sees its fields (zeroed when empty).
module fetch_decode_queue #(
   parameter  int DEPTH = 4,
   parameter  int PC_W  = 32,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IF_Flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [PC_W-1:0]  PC_next,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       opcode,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      offset,
   output logic [25:0]      imm,
   output logic [PC_W-1:0]  PC_next_IF,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 32 + PC_W;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop;
   logic [ENTRY_W-1:0] head;
   logic [31:0]        head_instr;

   // Handshake readiness depends only on occupancy, so a full queue never accepts a push.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (IF_Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {PC_next, instruction};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign head_instr = out_valid ? head[31:0] : 32'h0;

   // An empty queue presents an all-zero NOP bubble instead of stale array contents.
   always_comb begin
      opcode     = {1'b0, head_instr[31:26]};
      rs1        = head_instr[25:21];
      rs2        = head_instr[20:16];
      rd         = head_instr[15:11];
      shamt      = head_instr[10:6];
      funct      = head_instr[5:0];
      offset     = head_instr[15:0];
      imm        = head_instr[25:0];
      PC_next_IF = out_valid ? head[ENTRY_W-1:32] : '0;
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - vector table, corner sequences and random run against a queue model
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             IF_Flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      instruction = '0;
   logic [PC_W-1:0]  PC_next = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [6:0]       opcode;
   logic [4:0]       rs1, rs2, rd, shamt;
   logic [5:0]       funct;
   logic [15:0]      offset;
   logic [25:0]      imm;
   logic [PC_W-1:0]  PC_next_IF;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;

   logic [63:0] mq [$];

   fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .IF_Flush(IF_Flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .PC_next(PC_next),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .shamt(shamt),
      .funct(funct), .offset(offset), .imm(imm),
      .PC_next_IF(PC_next_IF), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] h;
      logic [31:0] hp;
      h  = (mq.size() > 0) ? mq[0][31:0] : 32'h0;
      hp = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("opcode", 64'(opcode), 64'(h >> 26));
      chk("rs1", 64'(rs1), 64'((h >> 21) & 32'h1f));
      chk("rs2", 64'(rs2), 64'((h >> 16) & 32'h1f));
      chk("rd", 64'(rd), 64'((h >> 11) & 32'h1f));
      chk("shamt", 64'(shamt), 64'((h >> 6) & 32'h1f));
      chk("funct", 64'(funct), 64'(h & 32'h3f));
      chk("offset", 64'(offset), 64'(h & 32'hffff));
      chk("imm", 64'(imm), 64'(h & 32'h3ff_ffff));
      chk("PC_next_IF", 64'(PC_next_IF), 64'(hp));
   endtask

   // One clock: drive at negedge, update the model at posedge, compare just after.
   task automatic cyc(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
      bit do_push, do_pop;
      @(negedge clk);
      reset = rst; IF_Flush = fl; in_valid = iv;
      instruction = ins; PC_next = pc; out_ready = ordy;
      @(posedge clk);
      if (rst || fl) begin
         mq.delete();
      end else begin
         do_push = iv && (mq.size() < DEPTH);
         do_pop  = ordy && (mq.size() > 0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({pc, ins});
      end
      #1;
      check_model();
   endtask

   function automatic logic [31:0] kw(input int k);
      return {6'(k), 26'(k)};
   endfunction

   function automatic logic [31:0] kp(input int k);
      return 32'h200 + 32'(4 * k);
   endfunction

   typedef struct {
      logic        rst, fl, iv;
      logic [31:0] ins, pc;
      logic        ordy;
      int          e_cnt;
      logic        e_ov, e_ir;
      logic [6:0]  e_op;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] ins, logic [31:0] pc,
                               logic ordy, int e_cnt, logic e_ov, logic e_ir,
                               logic [6:0] e_op, logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy;
      v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_op = e_op; v.e_pc = e_pc;
      return v;
   endfunction

   initial begin
      // single pass of a lw
      vt.push_back(mk(0, 0, 1, 32'h8C41_0004, 32'h104, 1, 1, 1, 1, 7'h23, 32'h104));
      vt.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 7'h00, 32'h0));
      // fill with decode stalled; fifth push refused
      for (int k = 1; k <= 5; k++)
         vt.push_back(mk(0, 0, 1, kw(k), kp(k), 0, (k > 4) ? 4 : k, 1, k < 4, 7'h01, kp(1)));
      for (int k = 2; k <= 4; k++)
         vt.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1, 5 - k, 1, 1, 7'(k), kp(k)));
      vt.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 7'h00, 32'h0));
      // flush at count 3 with push and pop offered
      for (int k = 9; k <= 11; k++)
         vt.push_back(mk(0, 0, 1, kw(k), kp(k), 0, k - 8, 1, 1, 7'd9, kp(9)));
      vt.push_back(mk(0, 1, 1, kw(12), kp(12), 1, 0, 0, 1, 7'h00, 32'h0));
      vt.push_back(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 7'h00, 32'h0));
      // opcode MSB, then reset at count 2
      vt.push_back(mk(0, 0, 1, 32'hFC00_0000, 32'h300, 0, 1, 1, 1, 7'h3F, 32'h300));
      vt.push_back(mk(0, 0, 1, kw(5), kp(5), 0, 2, 1, 1, 7'h3F, 32'h300));
      vt.push_back(mk(1, 0, 1, kw(6), kp(6), 1, 0, 0, 1, 7'h00, 32'h0));

      repeat (2) @(posedge clk);
      cyc(1, 0, 0, 32'h0, 32'h0, 0);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_opcode", 64'(opcode), 64'd0);
      chk("reset_imm", 64'(imm), 64'd0);
      chk("reset_pc", 64'(PC_next_IF), 64'd0);

      foreach (vt[i]) begin
         cyc(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ins, vt[i].pc, vt[i].ordy);
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
         chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
         chk($sformatf("vec%0d_opcode", i), 64'(opcode), 64'(vt[i].e_op));
         chk($sformatf("vec%0d_pc", i), 64'(PC_next_IF), 64'(vt[i].e_pc));
      end

      // steady push+pop at count 2 wraps both pointers in order
      cyc(0, 0, 1, kw(20), kp(20), 0);
      cyc(0, 0, 1, kw(21), kp(21), 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, kw(22 + i), kp(22 + i), 1);
         chk("pp_count", 64'(count), 64'd2);
         chk("pp_head", 64'(opcode), 64'(21 + i));
      end

      // random traffic against the queue model
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
             1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised IF/ID stage buffer that replaces the single-entry IF/ID register with a DEPTH-entry circular instruction queue. Fetch pushes {instruction, PC_next} under a valid/ready handshake. Decode pops the head entry, and the field split (opcode, rs1, rs2, rd, shamt, funct, offset, imm) is taken from that head entry. The queue absorbs decode stalls without stalling fetch, and IF_Flush discards all in-flight entries on a branch or jump redirect.

Parameters:
DEPTH, 4, number of queue entries; power of 2, >= 2
PC_W, 32, width of the PC_next field
CNT_W, $clog2(DEPTH)+1, occupancy counter width (localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
IF_Flush  in  1  discard all entries (branch/jump redirect)
in_valid  in  1  fetch presents an instruction this cycle
in_ready  out  1  queue can accept a push; = (count != DEPTH)
instruction  in  32  fetched instruction word
PC_next  in  PC_W  PC+4 of the fetched instruction
out_valid  out  1  head entry valid; = (count != 0)
out_ready  in  1  decode consumes the head this cycle (0 = decode stall)
opcode  out  7  {1'b0, head[31:26]}; zero-extended so MSB=1 never reads as negative
rs1  out  5  head[25:21]
rs2  out  5  head[20:16]
rd  out  5  head[15:11]
shamt  out  5  head[10:6]
funct  out  6  head[5:0]
offset  out  16  head[15:0]
imm  out  26  head[25:0]
PC_next_IF  out  PC_W  PC_next of head entry
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x (32+PC_W) array; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0; count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready depends only on count, never combinationally on out_ready. A push while full is not accepted, even when a pop happens in the same cycle.
- Push writes array[wr_ptr] and advances wr_ptr. Pop advances rd_ptr.
- count updates: +1 on push only; -1 on pop only; unchanged when push and pop coincide.
- Latency: a push into an empty queue is visible on out_valid/fields on the next cycle. There is no same-cycle bypass.
- Decode outputs are combinational from array[rd_ptr] when out_valid=1. When out_valid=0, all field outputs and PC_next_IF are forced to 0 (NOP bubble), so decode never sees stale data.
- Priority, highest first: reset > IF_Flush > push/pop.
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, count=0. Next cycle out_valid=0, in_ready=1, and all field outputs are 0. Array contents are don't-care. Reset asserted mid-stream drops all entries.
- IF_Flush: wr_ptr=0, rd_ptr=0, count=0 on that edge. A push and pop in the flush cycle are both ignored; the instruction presented that cycle is wrong-path and is dropped. out_valid=0 from the next cycle.
- Pop on empty and push on full cannot occur, because the handshake qualifiers mask them.
- Occupancy invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and the queue is full.

Test Plan:
- Reset then idle: assert reset 1 cycle -> count=0, out_valid=0, in_ready=1, opcode=0, imm=0, PC_next_IF=0.
- Single pass: push 0x8C41_0004 (lw), PC_next=0x0000_0104, out_ready=1 -> next cycle out_valid=1, opcode=7'h23, rs1=2, rs2=1, offset=16'h0004, PC_next_IF=0x104; following cycle out_valid=0.
- Fill/stall: out_ready=0, push 5 words (DEPTH=4) -> count=4, in_ready=0 after the 4th push, 5th not accepted; then out_ready=1 -> pops emerge in push order, one per cycle.
- Simultaneous push/pop at count=2 -> count stays 2; 10 such cycles wrap both pointers with FIFO order preserved.
- Flush: count=3 with in_valid=1 and out_ready=1 in the flush cycle -> next cycle count=0, out_valid=0; the flush-cycle instruction never appears at the output.
- Opcode MSB: push 0xFC00_0000 -> opcode=7'h3F (not negative), imm=26'h0; reset asserted at count=2 -> all outputs 0 next cycle.
